// File: rtl/serial_subtractor_pkg.sv
// Shared ALU subtractor definitions: datapath width, FSM encodings, flag helper.
// Pure declarations; no timing or flow control.
package serial_subtractor_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Two's-complement overflow of a subtraction, from operand sign bits and result sign bit.
    function automatic logic sub_signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtract cell: diff = a - b - bin with borrow out.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, with borrow/zero/overflow flags.
// Done pulses WIDTH cycles after the accepting edge; start is ignored while busy.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             zero,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             bit_diff;
    logic             bit_bout;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    // Result fills from the MSB side so bit 0 lands in place after WIDTH shifts.
    assign res_nxt = {bit_diff, res_sr[WIDTH-1:1]};
    assign busy    = (state == ST_RUN);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sr  <= A;
                b_sr  <= B;
                br    <= Bin;
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
                count <= '0;
            end else if (step) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                br     <= bit_bout;
                res_sr <= res_nxt;
                count  <= count + CW'(1);
                // Visible outputs only move here, so partial results never leak out.
                if (last) begin
                    Diff <= res_nxt;
                    Bout <= bit_bout;
                    zero <= (res_nxt == '0);
                    ovf  <= sub_signed_ovf(a_msb, b_msb, res_nxt[WIDTH-1]);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor results, flags, latency and handshake.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [7:0] Diff;
    logic       Bout;
    logic       zero;
    logic       ovf;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_exp = 8'h00;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one operation; b2b launches in the current (done) cycle instead of waiting.
    // ignore_at > 0 pulses a competing start that many cycles after acceptance.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [7:0] e_diff, input logic e_bout, input logic e_zero,
                         input logic e_ovf, input bit b2b, input int ignore_at);
        int lat;
        int busy_cnt;
        if (!b2b) @(negedge clk);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        Bin      = 1'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (lat == 4) check({tag, "_hold"}, Diff, last_exp);
            @(posedge clk);
            #1;
            lat++;
            start = (lat == ignore_at);
            if (start) begin
                A   = 8'h01;
                B   = 8'h01;
                Bin = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busycyc"}, busy_cnt, 8);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_diff"}, Diff, e_diff);
        check({tag, "_bout"}, Bout, e_bout);
        check({tag, "_zero"}, zero, e_zero);
        check({tag, "_ovf"}, ovf, e_ovf);
        last_exp = e_diff;
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        bit         seen;
        int         gap;

        rst   = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", Diff, 8'h00);
        check("rst_flags", {Bout, zero, ovf}, 3'b000);
        rst = 1'b0;

        do_op("v50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("diff_holds", Diff, 8'h30);

        do_op("v10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        do_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        do_op("v7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        do_op("v05_05", 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op("v00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        do_op("ignore", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        do_op("b2b", 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Reset mid-flight: everything clears and the abandoned op never completes.
        @(negedge clk);
        A     = 8'h50;
        B     = 8'h20;
        Bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_diff", Diff, 8'h00);
        check("midrst_flags", {Bout, zero, ovf}, 3'b000);
        rst      = 1'b0;
        last_exp = 8'h00;
        seen     = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("midrst_no_done", seen, 1'b0);
        do_op("after_rst", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 2000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            r    = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
            gap  = $urandom_range(0, 3);
            if (gap > 1) repeat (gap - 1) @(negedge clk);
            do_op("rand", ra, rb, rbin, r[7:0], r[8], (r[7:0] == 8'h00),
                  (ra[7] ^ rb[7]) & (r[7] ^ ra[7]), (gap == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
